// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package reg_file_pkg;
  localparam int DEF_M = 32;
  localparam int DEF_N = 32;

  typedef logic [DEF_M-1:0]         reg_data_t;
  typedef logic [$clog2(DEF_N)-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_file_sb_busy_table.sv
// Busy table: per-register pending-write bits plus their population count; set beats clear
// on the same index, both take effect at the edge, synchronous active-high reset.
module busy_table
  import reg_file_pkg::*;
#(
  parameter  int N      = DEF_N,
  localparam int addrSz = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_vld,
  input  logic [addrSz-1:0] i_set_idx,
  input  logic              i_clr_vld,
  input  logic [addrSz-1:0] i_clr_idx,
  output logic [N-1:0]      o_busy,
  output logic [addrSz:0]   o_pending_cnt
);
  logic [N-1:0]    r_busy;
  logic [N-1:0]    w_busy_nxt;
  logic [addrSz:0] r_cnt;
  logic            w_inc;
  logic            w_dec;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_vld) w_busy_nxt[i_clr_idx] = 1'b0;
    if (i_set_vld) w_busy_nxt[i_set_idx] = 1'b1;
    // A clear that a same-index set overrides removes nothing from the count.
    w_inc = i_set_vld && !r_busy[i_set_idx];
    w_dec = i_clr_vld && r_busy[i_clr_idx] && !(i_set_vld && (i_set_idx == i_clr_idx));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= r_cnt + (addrSz+1)'(w_inc) - (addrSz+1)'(w_dec);
    end
  end

  assign o_busy        = r_busy;
  assign o_pending_cnt = r_cnt;
endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: 0-cycle reads, edge writes, combinational RAW/WAW stall on issue.
// REG_FILE_BYPASS_EN forwards the writeback data and releases its busy bit in the writeback cycle.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int M      = DEF_M,
  parameter  int N      = DEF_N,
  localparam int addrSz = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [addrSz-1:0] Ra,
  input  logic [addrSz-1:0] Rb,
  output logic [M-1:0]      Ra_data,
  output logic [M-1:0]      Rb_data,
  input  logic              issue_valid,
  input  logic [addrSz-1:0] issue_Rd,
  output logic              stall,
  input  logic              w_enable,
  input  logic [addrSz-1:0] Rd,
  input  logic [M-1:0]      Wdata,
  output logic [N-1:0]      busy,
  output logic [addrSz:0]   pending_cnt
);
  localparam logic [addrSz-1:0] ZR = addrSz'(ZERO_REG);

  logic [M-1:0] r_mem [N];
  logic         w_wr;
  logic         w_issue;
  logic         w_byp_a;
  logic         w_byp_b;
  logic [N-1:0] w_clr_mask;
  logic [N-1:0] w_busy_eff;

  assign w_wr = w_enable && (Rd != ZR);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[Rd] <= Wdata;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign w_byp_a    = w_wr && (Ra == Rd);
  assign w_byp_b    = w_wr && (Rb == Rd);
  assign w_clr_mask = w_wr ? ({{(N-1){1'b0}}, 1'b1} << Rd) : '0;
`else
  assign w_byp_a    = 1'b0;
  assign w_byp_b    = 1'b0;
  assign w_clr_mask = '0;
`endif

  assign Ra_data = (Ra == ZR) ? '0 : (w_byp_a ? Wdata : r_mem[Ra]);
  assign Rb_data = (Rb == ZR) ? '0 : (w_byp_b ? Wdata : r_mem[Rb]);

  assign w_busy_eff = busy & ~w_clr_mask;
  assign stall      = issue_valid && (w_busy_eff[Ra] || w_busy_eff[Rb] || w_busy_eff[issue_Rd]);
  assign w_issue    = issue_valid && !stall && (issue_Rd != ZR);

  busy_table #(.N(N)) u_busy_table (
    .clk           (clk),
    .reset         (reset),
    .i_set_vld     (w_issue),
    .i_set_idx     (issue_Rd),
    .i_clr_vld     (w_wr),
    .i_clr_idx     (Rd),
    .o_busy        (busy),
    .o_pending_cnt (pending_cnt)
  );
endmodule
